// File: rtl/alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_sequencer
// Brief    : Multi-cycle execute controller: read operands, drive ALU,
//            write back result and flags, own the PSR.
// Revision : 1.0
// ============================================================================
module alu_exec_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int FLAG_WIDTH     = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmdValid,
    output logic                      cmdReady,
    input  logic [4:0]                cmdOp,
    input  logic [REG_ADDR_WIDTH-1:0] cmdDst,
    input  logic [REG_ADDR_WIDTH-1:0] cmdSrcA,
    input  logic [REG_ADDR_WIDTH-1:0] cmdSrcB,
    input  logic                      cmdUseImm,
    input  logic [DATA_WIDTH-1:0]     cmdImm,
    output logic [REG_ADDR_WIDTH-1:0] rfRaddrA,
    output logic [REG_ADDR_WIDTH-1:0] rfRaddrB,
    input  logic [DATA_WIDTH-1:0]     rfRdataA,
    input  logic [DATA_WIDTH-1:0]     rfRdataB,
    output logic                      rfWe,
    output logic [REG_ADDR_WIDTH-1:0] rfWaddr,
    output logic [DATA_WIDTH-1:0]     rfWdata,
    output logic [DATA_WIDTH-1:0]     aluInput1,
    output logic [DATA_WIDTH-1:0]     aluInput2,
    output logic [4:0]                aluOp,
    output logic [FLAG_WIDTH-1:0]     aluInFlags,
    input  logic [FLAG_WIDTH-1:0]     aluOutFlags,
    input  logic [DATA_WIDTH-1:0]     aluResult,
    input  logic                      psrWe,
    input  logic [FLAG_WIDTH-1:0]     psrWdata,
    output logic [FLAG_WIDTH-1:0]     psr,
    output logic                      done,
    output logic                      illegalOp
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam logic [4:0] c_OP_CMP  = 5'd6;
    localparam logic [4:0] c_OP_CMPU = 5'd7;

    state_e                    state_q, state_d;
    logic [4:0]                op_q;
    logic [REG_ADDR_WIDTH-1:0] dst_q;
    logic [REG_ADDR_WIDTH-1:0] src_a_q;
    logic [REG_ADDR_WIDTH-1:0] src_b_q;
    logic                      use_imm_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [FLAG_WIDTH-1:0]     flags_q;
    logic [FLAG_WIDTH-1:0]     psr_q, psr_d;

    logic w_accept;
    logic w_op_legal;
    logic w_flag_op;
    logic w_writes_rf;

    assign w_accept    = cmdValid && (state_q == S_IDLE);
    assign w_op_legal  = (cmdOp != 5'd0) && !cmdOp[4];
    assign w_flag_op   = (op_q <= c_OP_CMPU);
    assign w_writes_rf = (op_q != c_OP_CMP) && (op_q != c_OP_CMPU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            psr_q     <= '0;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
            if (w_accept) begin
                op_q      <= cmdOp;
                dst_q     <= cmdDst;
                src_a_q   <= cmdSrcA;
                src_b_q   <= cmdSrcB;
                use_imm_q <= cmdUseImm;
                imm_q     <= cmdImm;
            end
            if (state_q == S_EXEC) begin
                result_q <= aluResult;
                flags_q  <= aluOutFlags;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cmdReady  = 1'b0;
        done      = 1'b0;
        illegalOp = 1'b0;
        rfWe      = 1'b0;
        aluInput1 = '0;
        aluInput2 = '0;
        aluOp     = '0;
        case (state_q)
            S_IDLE: begin
                cmdReady = 1'b1;
                if (cmdValid) begin
                    state_d = w_op_legal ? S_READ : S_ERR;
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                aluInput1 = rfRdataA;
                aluInput2 = use_imm_q ? imm_q : rfRdataB;
                aluOp     = op_q;
                state_d   = S_WB;
            end
            S_WB: begin
                done    = 1'b1;
                rfWe    = w_writes_rf;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done      = 1'b1;
                illegalOp = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ALU flags of a flag-updating op take priority over an external PSR load.
    always_comb begin
        psr_d = psr_q;
        if (psrWe) begin
            psr_d = psrWdata;
        end
        if ((state_q == S_WB) && w_flag_op) begin
            psr_d = flags_q;
        end
    end

    assign rfRaddrA   = src_a_q;
    assign rfRaddrB   = src_b_q;
    assign rfWaddr    = dst_q;
    assign rfWdata    = result_q;
    assign aluInFlags = psr_q;
    assign psr        = psr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_sequencer
// Brief    : Bench with register file, ALU and a command-level reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [4:0]  cmdOp = '0;
    logic [3:0]  cmdDst = '0, cmdSrcA = '0, cmdSrcB = '0;
    logic        cmdUseImm = 1'b0;
    logic [15:0] cmdImm = '0;
    logic [3:0]  rfRaddrA, rfRaddrB, rfWaddr;
    logic [15:0] rfRdataA = '0, rfRdataB = '0, rfWdata;
    logic        rfWe;
    logic [15:0] aluInput1, aluInput2, aluResult;
    logic [4:0]  aluOp, aluInFlags, aluOutFlags;
    logic        psrWe = 1'b0;
    logic [4:0]  psrWdata = '0;
    logic [4:0]  psr;
    logic        done, illegalOp;

    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_sequencer #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4), .FLAG_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdDst(cmdDst),
        .cmdSrcA(cmdSrcA), .cmdSrcB(cmdSrcB), .cmdUseImm(cmdUseImm), .cmdImm(cmdImm),
        .rfRaddrA(rfRaddrA), .rfRaddrB(rfRaddrB), .rfRdataA(rfRdataA), .rfRdataB(rfRdataB),
        .rfWe(rfWe), .rfWaddr(rfWaddr), .rfWdata(rfWdata),
        .aluInput1(aluInput1), .aluInput2(aluInput2), .aluOp(aluOp),
        .aluInFlags(aluInFlags), .aluOutFlags(aluOutFlags), .aluResult(aluResult),
        .psrWe(psrWe), .psrWdata(psrWdata), .psr(psr), .done(done), .illegalOp(illegalOp)
    );

    // ALU: flags {N,Z,F,L,C}; CMP/CMPU report Z/L/N from the comparison.
    function automatic logic [20:0] alu_f(input logic [4:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [4:0] fi);
        logic [16:0] s;
        logic [15:0] r;
        logic [4:0]  f;
        logic        cin;
        s = '0; r = '0; f = '0;
        cin = (op == 5'd3 || op == 5'd4) ? fi[0] : 1'b0;
        case (op)
            5'd1, 5'd2, 5'd3, 5'd4: begin
                s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                r = s[15:0];
                f[0] = s[16];
                f[2] = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'd5: begin
                r = a - b;
                f[0] = (a < b);
                f[2] = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'd6, 5'd7: r = a - b;
            5'd8:  r = a & b;
            5'd9:  r = a | b;
            5'd10: r = a ^ b;
            5'd11: r = ~a;
            5'd12, 5'd14: r = a << b[3:0];
            5'd13: r = a >> b[3:0];
            5'd15: r = 16'($signed(a) >>> b[3:0]);
            default: r = '0;
        endcase
        if (op == 5'd6 || op == 5'd7) begin
            f[3] = (a == b);
            f[1] = (a < b);
            f[4] = ($signed(a) < $signed(b));
        end else begin
            f[3] = (r == 16'd0);
            f[4] = r[15];
        end
        return {f, r};
    endfunction

    assign {aluOutFlags, aluResult} = alu_f(aluOp, aluInput1, aluInput2, aluInFlags);

    logic [15:0] rf [16];
    always @(posedge clk) begin
        rfRdataA <= rf[rfRaddrA];
        rfRdataB <= rf[rfRaddrB];
        if (rfWe) rf[rfWaddr] <= rfWdata;
        if (pre_we) rf[pre_addr] <= pre_data;
    end

    // Reference model: one outstanding command, tracked by cycles since accept.
    logic [15:0] mrf [16];
    logic        pend = 1'b0, p_ill = 1'b0, p_imm_use = 1'b0;
    int          age = 0;
    logic [4:0]  p_op = '0, mpsr = '0, np = '0, m_flags = '0;
    logic [3:0]  p_dst = '0, p_a = '0, p_b = '0;
    logic [15:0] p_imm = '0, m_res = '0;

    function automatic logic m_writes(input logic [4:0] op);
        return !(op == 5'd6 || op == 5'd7);
    endfunction

    always @(posedge clk) begin
        if (pre_we) mrf[pre_addr] = pre_data;
        if (!rst_n) begin
            pend = 1'b0; age = 0; mpsr = '0;
        end else begin
            np = psrWe ? psrWdata : mpsr;
            if (pend && !p_ill && age == 2)
                {m_flags, m_res} = alu_f(p_op, mrf[p_a], p_imm_use ? p_imm : mrf[p_b], mpsr);
            if (pend && !p_ill && age == 3) begin
                if (p_op <= 5'd7) np = m_flags;
                if (m_writes(p_op)) mrf[p_dst] = m_res;
            end
            mpsr = np;
            if (pend) begin
                if ((p_ill && age == 1) || age == 3) pend = 1'b0;
                else age = age + 1;
            end else if (cmdValid) begin
                pend = 1'b1; age = 1;
                p_op = cmdOp; p_dst = cmdDst; p_a = cmdSrcA; p_b = cmdSrcB;
                p_imm_use = cmdUseImm; p_imm = cmdImm;
                p_ill = (cmdOp == 5'd0) || (cmdOp > 5'd15);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", 32'(cmdReady), 32'd1);
            chk("rst_rfwe", 32'(rfWe), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_illegal", 32'(illegalOp), 32'd0);
            chk("rst_psr", 32'(psr), 32'd0);
            chk("rst_aluop", 32'(aluOp), 32'd0);
        end else begin
            chk("ready", 32'(cmdReady), 32'(!pend));
            chk("done", 32'(done), 32'(pend && (p_ill ? age == 1 : age == 3)));
            chk("illegal", 32'(illegalOp), 32'(pend && p_ill && age == 1));
            chk("rfwe", 32'(rfWe), 32'(pend && !p_ill && age == 3 && m_writes(p_op)));
            chk("psr", 32'(psr), 32'(mpsr));
            chk("alu_inflags", 32'(aluInFlags), 32'(mpsr));
            if (pend && !p_ill && age == 1) begin
                chk("raddr_a", 32'(rfRaddrA), 32'(p_a));
                chk("raddr_b", 32'(rfRaddrB), 32'(p_b));
            end
            if (pend && !p_ill && age == 2) begin
                chk("alu_op", 32'(aluOp), 32'(p_op));
                chk("alu_in1", 32'(aluInput1), 32'(mrf[p_a]));
                chk("alu_in2", 32'(aluInput2), 32'(p_imm_use ? p_imm : mrf[p_b]));
            end else begin
                chk("alu_op_idle", 32'(aluOp), 32'd0);
            end
            if (rfWe) begin
                chk("waddr", 32'(rfWaddr), 32'(p_dst));
                chk("wdata", 32'(rfWdata), 32'(m_res));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    // Returns in the cycle right after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [3:0] dst, input logic [3:0] sa,
                         input logic [3:0] sb, input logic ui, input logic [15:0] imm);
        int guard;
        guard = 0;
        while (!cmdReady && guard < 20) begin
            step();
            guard++;
        end
        if (!cmdReady) chk("ready_timeout", 32'(cmdReady), 32'd1);
        cmdOp = op; cmdDst = dst; cmdSrcA = sa; cmdSrcB = sb; cmdUseImm = ui; cmdImm = imm;
        cmdValid = 1'b1;
        step();
        cmdValid = 1'b0;
    endtask

    initial begin
        #1;
        for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
        rst_n = 1'b1;
        step();

        // ADD 4 + 17 -> R3
        preload(4'd1, 16'd4);
        preload(4'd2, 16'd17);
        issue(5'd1, 4'd3, 4'd1, 4'd2, 1'b0, 16'd0);
        step(); step();
        chk("add_we", 32'(rfWe), 32'd1);
        chk("add_waddr", 32'(rfWaddr), 32'd3);
        chk("add_wdata", 32'(rfWdata), 32'd21);
        chk("add_done", 32'(done), 32'd1);
        step();
        chk("add_z", 32'(psr[3]), 32'd0);
        chk("add_done_pulse", 32'(done), 32'd0);

        // CMP 17, 17
        preload(4'd1, 16'd17);
        issue(5'd6, 4'd5, 4'd1, 4'd2, 1'b0, 16'd0);
        step(); step();
        chk("cmp_we", 32'(rfWe), 32'd0);
        chk("cmp_done", 32'(done), 32'd1);
        step();
        chk("cmp_psr", 32'(psr), 32'h08);

        // PSR load then ADDC imm 17 + R1(4) + C
        preload(4'd1, 16'd4);
        psrWe = 1'b1; psrWdata = 5'b00001;
        step();
        psrWe = 1'b0;
        issue(5'd3, 4'd6, 4'd1, 4'd2, 1'b1, 16'd17);
        step();
        chk("addc_cin", 32'(aluInFlags[0]), 32'd1);
        chk("addc_in2", 32'(aluInput2), 32'd17);
        step();
        chk("addc_wdata", 32'(rfWdata), 32'd22);
        step();

        // Illegal opcodes
        issue(5'd0, 4'd9, 4'd1, 4'd2, 1'b0, 16'd0);
        chk("ill0_done", 32'(done), 32'd1);
        chk("ill0_flag", 32'(illegalOp), 32'd1);
        chk("ill0_we", 32'(rfWe), 32'd0);
        step();
        chk("ill0_psr", 32'(psr), 32'd0);
        issue(5'd20, 4'd9, 4'd1, 4'd2, 1'b0, 16'd0);
        chk("ill20_done", 32'(done), 32'd1);
        chk("ill20_flag", 32'(illegalOp), 32'd1);
        step();
        chk("ill20_psr", 32'(psr), 32'd0);

        // SUB 4 - 17 with a competing PSR load in WB
        issue(5'd5, 4'd7, 4'd1, 4'd2, 1'b0, 16'd0);
        step(); step();
        psrWe = 1'b1; psrWdata = 5'b01010;
        chk("sub_wdata", 32'(rfWdata), 32'hFFF3);
        step();
        psrWe = 1'b0;
        chk("sub_psr", 32'(psr), 32'h11);

        // Reset in the middle of EXEC
        issue(5'd1, 4'd8, 4'd1, 4'd2, 1'b0, 16'd0);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(cmdReady), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("rst_mid_psr", 32'(psr), 32'd0);
        rst_n = 1'b1;
        step();
        issue(5'd1, 4'd8, 4'd1, 4'd2, 1'b0, 16'd0);
        step(); step();
        chk("post_rst_we", 32'(rfWe), 32'd1);
        chk("post_rst_wdata", 32'(rfWdata), 32'd21);
        step();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cmdValid  = ($urandom_range(0, 2) != 0);
            cmdOp     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) * 5'($urandom_range(0, 1))
                                                    : 5'($urandom_range(1, 15));
            cmdDst    = 4'($urandom);
            cmdSrcA   = 4'($urandom);
            cmdSrcB   = 4'($urandom);
            cmdUseImm = 1'($urandom);
            cmdImm    = 16'($urandom);
            psrWe     = ($urandom_range(0, 7) == 0);
            psrWdata  = 5'($urandom);
            step();
        end
        cmdValid = 1'b0;
        psrWe = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
